// File: rtl/fft_bfly_sched_if.sv
// Bus between the radix-2 FFT butterfly sequencer and its environment:
// start/mode from the FFT controller, read/write/twiddle strobes towards RAM, ROM and butterfly.
interface fft_bfly_sched_if #(
  parameter int LOG2N = 8
);
  localparam int SW = $clog2(LOG2N);

  logic             start;
  logic             fft_ifft;
  logic             cfg_fft_ifft;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr0;
  logic [LOG2N-1:0] rd_addr1;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr0;
  logic [LOG2N-1:0] wr_addr1;
  logic [SW-1:0]    stage;
  logic             busy;
  logic             done;

  modport master (
    input  start, fft_ifft,
    output cfg_fft_ifft, rd_en, rd_addr0, rd_addr1, tw_addr,
           wr_en, wr_addr0, wr_addr1, stage, busy, done
  );

  modport slave (
    output start, fft_ifft,
    input  cfg_fft_ifft, rd_en, rd_addr0, rd_addr1, tw_addr,
           wr_en, wr_addr0, wr_addr1, stage, busy, done
  );
endinterface

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT FFT/IFFT sequencer: one butterfly per cycle, LOG2N stages,
// write-back addresses are the read addresses delayed by the butterfly latency.
module fft_bfly_sched #(
  parameter int LOG2N  = 8,
  parameter int BF_LAT = 2
) (
  input logic               clk,
  input logic               rst_n,
  fft_bfly_sched_if.master  bus
);
  localparam int NB = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [NB-1:0]    B_LAST = '1;
  localparam logic [SW-1:0]    S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0]    D_LAST = DW'(BF_LAT - 1);
  localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic             en;
    logic [LOG2N-1:0] a0;
    logic [LOG2N-1:0] a1;
  } wr_slot_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [NB-1:0]    b_q, b_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             cfg_q, cfg_d;

  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_addr0_q, rd_addr0_d, rd_addr1_q, rd_addr1_d;
  logic [LOG2N-2:0] tw_q, tw_d;
  logic [LOG2N-1:0] b_ext, half, idx, grp;
  logic             busy, done;

  wr_slot_t         rd_slot;
  wr_slot_t         dly_q [BF_LAT];

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      b_q     <= '0;
      dcnt_q  <= '0;
      cfg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
      dcnt_q  <= dcnt_d;
      cfg_q   <= cfg_d;
    end
  end

  // NOTE: every next-state variable gets a hold default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    dcnt_d  = dcnt_q;
    cfg_d   = cfg_q;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_RUN;
        cfg_d   = bus.fft_ifft;
        stage_d = '0;
        b_d     = '0;
      end
      S_RUN: if (b_q == B_LAST) begin
        state_d = S_DRAIN;
        dcnt_d  = '0;
      end else begin
        b_d = b_q + NB'(1);
      end
      S_DRAIN: if (dcnt_q == D_LAST) begin
        if (stage_q == S_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          stage_d = stage_q + SW'(1);
          b_d     = '0;
        end
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Addresses are formed from the next-cycle (stage, b) so they can be registered with rd_en.
  always_comb begin
    rd_en_d    = (state_d == S_RUN);
    b_ext      = {1'b0, b_d};
    half       = ONE << stage_d;
    idx        = b_ext & (half - ONE);
    grp        = b_ext >> stage_d;
    rd_addr0_d = (grp << (int'(stage_d) + 1)) | idx;
    rd_addr1_d = rd_addr0_d + half;
    tw_d       = (LOG2N-1)'(idx << (LOG2N - 1 - int'(stage_d)));
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q    <= 1'b0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      tw_q       <= '0;
    end else begin
      rd_en_q <= rd_en_d;
      if (rd_en_d) begin
        rd_addr0_q <= rd_addr0_d;
        rd_addr1_q <= rd_addr1_d;
        tw_q       <= tw_d;
      end
    end
  end

  assign rd_slot = '{en: rd_en_q, a0: rd_addr0_q, a1: rd_addr1_q};

  // NOTE: unlike a data RAM this delay line is reset, because an aborted transform
  // must not emit a stale write strobe after rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BF_LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= rd_slot;
      for (int i = 1; i < BF_LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign bus.cfg_fft_ifft = cfg_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.rd_addr0     = rd_addr0_q;
  assign bus.rd_addr1     = rd_addr1_q;
  assign bus.tw_addr      = tw_q;
  assign bus.wr_en        = dly_q[BF_LAT-1].en;
  assign bus.wr_addr0     = dly_q[BF_LAT-1].a0;
  assign bus.wr_addr1     = dly_q[BF_LAT-1].a1;
  assign bus.stage        = stage_q;
  assign bus.busy         = busy;
  assign bus.done         = done;
endmodule
